// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execute-stage state encoding.
// The decoder and the iterative execute unit both draw their codes from here.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_XOR = 4'd2,
        ALU_OR  = 4'd3,
        ALU_AND = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LST = 4'd7,
        ALU_MUL = 4'd8,
        ALU_DIV = 4'd9,
        ALU_NA  = 4'd15
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } alu_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider producing one quotient bit per cycle on operand
// magnitudes; the sign fix-up is applied to the final quotient.
module div_iter #(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH:0]   rem_shift_s, diff_s;
    logic [WIDTH-1:0] rem_step_s, quo_step_s;
    logic             last_s;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        if (dividend_i[WIDTH-1]) begin
            a_mag_s = ~dividend_i + WIDTH'(1);
        end else begin
            a_mag_s = dividend_i;
        end
        if (divisor_i[WIDTH-1]) begin
            b_mag_s = ~divisor_i + WIDTH'(1);
        end else begin
            b_mag_s = divisor_i;
        end
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_q};
        if (!diff_s[WIDTH]) begin
            rem_step_s = diff_s[WIDTH-1:0];
            quo_step_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = rem_shift_s[WIDTH-1:0];
            quo_step_s = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign last_s = (cnt_q == CNT_W'(DIV_ITERS - 1));

    // Next-state: load on start, iterate while busy, otherwise hold.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        neg_d  = neg_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (start_i && !busy_q) begin
            rem_d  = {WIDTH{1'b0}};
            quo_d  = a_mag_s;
            dvs_d  = b_mag_s;
            // Division by zero keeps the all-ones magnitude unnegated, i.e. -1.
            neg_d  = (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]) && (divisor_i != {WIDTH{1'b0}});
            busy_d = 1'b1;
            cnt_d  = {CNT_W{1'b0}};
        end else if (busy_q) begin
            rem_d = rem_step_s;
            quo_d = quo_step_s;
            if (last_s) begin
                busy_d = 1'b0;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= {WIDTH{1'b0}};
            quo_q  <= {WIDTH{1'b0}};
            dvs_q  <= {WIDTH{1'b0}};
            neg_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            neg_q  <= neg_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && last_s;
    assign quotient_o = neg_q ? (~quo_step_s + WIDTH'(1)) : quo_step_s;

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with valid/ready handshake: single-cycle ops complete in
// one cycle, signed division runs iteratively while Stall freezes the front end.
module alu_iter_exec
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Stall
);

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             stall_q;

    logic             in_ready_s;
    logic             accept_s;
    logic             div_start_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             div_busy_s;
    logic             div_done_s;
    logic [WIDTH-1:0] div_quot_s;

    assign in_ready_s  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept_s    = in_valid && in_ready_s;
    assign div_start_s = accept_s && is_div_op(ALUOp);

    // Single-cycle operation results.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (ALUOp)
            ALU_ADD: alu_res_s = SrcA + SrcB;
            ALU_SUB: alu_res_s = SrcA - SrcB;
            ALU_XOR: alu_res_s = SrcA ^ SrcB;
            ALU_OR:  alu_res_s = SrcA | SrcB;
            ALU_AND: alu_res_s = SrcA & SrcB;
            ALU_SLL: alu_res_s = SrcA << SrcB[4:0];
            ALU_SRL: alu_res_s = SrcA >> SrcB[4:0];
            ALU_LST: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_MUL: alu_res_s = SrcA * SrcB;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    div_iter #(
        .WIDTH     (WIDTH),
        .DIV_ITERS (DIV_ITERS)
    ) u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start_s),
        .dividend_i (SrcA),
        .divisor_i  (SrcB),
        .busy_o     (div_busy_s),
        .done_o     (div_done_s),
        .quotient_o (div_quot_s)
    );

    // Handshake FSM with registered result, Zero and Stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stall_q <= 1'b0;
                    if (accept_s && is_div_op(ALUOp)) begin
                        state_q     <= ST_DIV;
                        out_valid_q <= 1'b0;
                        zero_q      <= 1'b0;
                    end else if (accept_s) begin
                        result_q    <= alu_res_s;
                        zero_q      <= (alu_res_s == {WIDTH{1'b0}});
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        zero_q      <= 1'b0;
                    end else begin
                        out_valid_q <= out_valid_q;
                    end
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        state_q     <= ST_IDLE;
                        result_q    <= div_quot_s;
                        zero_q      <= (div_quot_s == {WIDTH{1'b0}});
                        out_valid_q <= 1'b1;
                        stall_q     <= 1'b0;
                    end else if (!div_busy_s) begin
                        // Divider lost its operation; recover rather than hang.
                        state_q <= ST_IDLE;
                        stall_q <= 1'b0;
                    end else begin
                        stall_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    zero_q      <= 1'b0;
                    stall_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Stall     = stall_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed scoreboard bench for alu_iter_exec: expected results are queued at
// drive time and popped when out_valid is observed on the falling edge.
module tb_alu_iter_exec;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Stall;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_iter_exec dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .Stall     (Stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present an op at a falling edge; returns at the falling edge after the accept edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input bit push);
        ALUOp    = op;
        SrcA     = a;
        SrcB     = b;
        in_valid = 1'b1;
        chkb("in_ready_at_accept", in_ready, 1'b1);
        if (push) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag);
        logic [31:0] e;
        chkb({tag, "_valid"}, out_valid, 1'b1);
        chkb({tag, "_sb_entry"}, (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, ALUResult, e);
            chkb({tag, "_zero"}, Zero, (e == 32'd0));
        end
    endtask

    task automatic div_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e);
        int lat;
        int stall_cnt;
        drive(ALU_DIV, a, b, e, 1'b1);
        // Scramble inputs and keep in_valid high briefly: both must be ignored.
        ALUOp = ALU_ADD;
        SrcA  = 32'h1234_5678;
        SrcB  = 32'h0000_0001;
        chkb({tag, "_in_ready_busy"}, in_ready, 1'b0);
        lat       = 0;
        stall_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) break;
            if (Stall) stall_cnt++;
            if (k == 4) in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd32);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd31);
        chkb({tag, "_stall_done"}, Stall, 1'b0);
        expect_out(tag);
        @(negedge clk);
        chkb({tag, "_consumed"}, out_valid, 1'b0);
    endtask

    initial begin
        int ov_cnt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUOp     = 4'd0;
        SrcA      = 32'd0;
        SrcB      = 32'd0;
        repeat (2) @(negedge clk);
        chkb("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", ALUResult, 32'd0);
        chkb("rst_zero", Zero, 1'b0);
        chkb("rst_stall", Stall, 1'b0);
        rst = 1'b0;
        chkb("rst_in_ready", in_ready, 1'b1);

        // ADD 5+7, latency 1
        drive(ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b1);
        in_valid = 1'b0;
        expect_out("add");
        @(negedge clk);
        chkb("add_consumed", out_valid, 1'b0);

        // SUB 9-9 held for 3 cycles with out_ready low; a blocked ADD is presented
        out_ready = 1'b0;
        drive(ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1);
        ALUOp = ALU_ADD;
        SrcA  = 32'd1;
        SrcB  = 32'd1;
        for (int i = 0; i < 3; i++) begin
            chkb("sub_hold_valid", out_valid, 1'b1);
            chk("sub_hold_result", ALUResult, 32'd0);
            chkb("sub_hold_zero", Zero, 1'b1);
            chkb("sub_hold_in_ready", in_ready, 1'b0);
            if (i < 2) @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expect_out("sub");
        @(negedge clk);
        chkb("sub_consumed", out_valid, 1'b0);
        chkb("sub_in_ready", in_ready, 1'b1);

        // Divisions
        div_case("div_m100_7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        div_case("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        div_case("div_by_zero", 32'd123, 32'd0, 32'hFFFF_FFFF);
        div_case("div_100_m7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        div_case("div_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3);

        // Reset 10 cycles into a division aborts it
        drive(ALU_DIV, 32'd1000, 32'd3, 32'd0, 1'b0);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chkb("abort_stall_before", Stall, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chkb("abort_stall", Stall, 1'b0);
        chkb("abort_in_ready", in_ready, 1'b1);
        ov_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) ov_cnt++;
            @(negedge clk);
        end
        chk("abort_no_result", 32'(ov_cnt), 32'd0);

        // Back-to-back single-cycle ops, one result per cycle
        vecs.push_back('{ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000});
        vecs.push_back('{ALU_SLL, 32'h0000_0001, 32'd31,        32'h8000_0000});
        vecs.push_back('{ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00});
        vecs.push_back('{ALU_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678});
        vecs.push_back('{ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00});
        vecs.push_back('{ALU_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000});
        vecs.push_back('{ALU_SLL, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006});
        vecs.push_back('{ALU_LST, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
        vecs.push_back('{ALU_LST, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000});
        vecs.push_back('{ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF});
        vecs.push_back('{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001});
        vecs.push_back('{ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
        vecs.push_back('{4'd12,   32'h1111_1111, 32'h2222_2222, 32'h0000_0000});
        vecs.push_back('{ALU_NA,  32'h1111_1111, 32'h2222_2222, 32'h0000_0000});
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
            expect_out($sformatf("b2b_%0d_op%0d", i, vecs[i].op));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chkb("b2b_drained", out_valid, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_iter_exec.md
ALU_ITER_EXEC -- requirements
Module: alu_iter_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits.
REQ-002 SHALL have parameter DIV_ITERS, default WIDTH, meaning divider iterations (one quotient bit per cycle).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream presents ALUOp/SrcA/SrcB.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port ALUOp  input  4  operation code from the ALU decoder.
REQ-008 SHALL have port SrcA  input  WIDTH  operand A.
REQ-009 SHALL have port SrcB  input  WIDTH  operand B.
REQ-010 SHALL have port out_valid  output  1  ALUResult/Zero hold a valid result.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-012 SHALL have port ALUResult  output  WIDTH  registered result.
REQ-013 SHALL have port Zero  output  1  high when ALUResult equals 0, qualified by out_valid.
REQ-014 SHALL have port Stall  output  1  high while a division is in progress; freezes PC upstream.

Function
REQ-015 SHALL accept an operation on a rising edge where in_valid and in_ready are both high (accept edge).
REQ-016 SHALL drive in_ready = (state==IDLE) and (not out_valid or out_ready).
REQ-017 SHALL, for all codes except ALU_DIV (9), load ALUResult at the accept edge so out_valid is high the following cycle (latency 1).
REQ-018 SHALL compute: ADD(0) A+B; SUB(1) A-B; XOR(2); OR(3); AND(4); SLL(5) A<<B[4:0]; SRL(6) logical A>>B[4:0]; LST(7) signed A<B gives 1 else 0; MUL(8) low WIDTH bits of A*B; NA(15) and undefined codes 10-14 give 0.
REQ-019 SHALL wrap ADD/SUB/MUL modulo 2^WIDTH without flags.
REQ-020 SHALL implement a state machine with states IDLE and DIV: IDLE to DIV on accept of ALU_DIV; DIV to IDLE on the edge completing iteration DIV_ITERS.
REQ-021 SHALL in DIV perform signed division (RV32M div semantics): restoring divide on magnitudes, with the quotient negated when the operand signs differ.
REQ-022 SHALL load the quotient into ALUResult and raise out_valid on the edge DIV_ITERS cycles after the accept edge (32 for default).
REQ-023 SHALL return all-ones (-1) for division by zero, after the same full latency.
REQ-024 SHALL return the most negative value for (most negative)/(-1), without fault.
REQ-025 SHALL hold Stall high from the cycle after the accept edge of ALU_DIV until the cycle out_valid rises; Stall is otherwise low.
REQ-026 SHALL keep in_ready low throughout DIV; in_valid in DIV is ignored.
REQ-027 SHALL hold ALUResult, Zero and out_valid stable while out_valid is high and out_ready is low.
REQ-028 SHALL clear out_valid on an edge with out_ready high, unless a new non-DIV accept on the same edge reloads it (back-to-back, one result per cycle).
REQ-029 SHALL ignore SrcA/SrcB/ALUOp changes after the accept edge; operands are latched.

Reset
REQ-030 SHALL on rst: state to IDLE, out_valid 0, ALUResult 0, Zero 0, Stall 0, iteration counter 0.
REQ-031 SHALL abort an in-flight division on rst with no result produced; in_ready high the cycle after rst deasserts.
REQ-032 SHALL give rst priority over any accept or consume on the same edge.

Structure
REQ-033 SHALL take ALUOp code constants (ALU_ADD..ALU_DIV, ALU_NA) and the state encoding from shared package alu_pkg, identical to the decoder's codes.
REQ-034 SHALL place the iterative restoring divider in one sub-module div_iter (start, operands, busy, done, quotient), with the FSM and handshake in alu_iter_exec.

Verification
REQ-035 SHALL cover: accept ADD 5+7, out_ready=1 -> out_valid next cycle, ALUResult 12, Zero 0.
REQ-036 SHALL cover: accept SUB 9-9 with out_ready=0 for 3 cycles -> ALUResult 0, Zero 1 held stable, in_ready 0 until consumed.
REQ-037 SHALL cover: accept DIV -100/7 -> Stall high 31 cycles, out_valid after 32 cycles, ALUResult 0xFFFFFFF2 (-14).
REQ-038 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; DIV 123/0 -> 0xFFFFFFFF, both after 32 cycles.
REQ-039 SHALL cover: rst asserted 10 cycles into DIV -> out_valid never rises, Stall 0 and in_ready 1 after reset.
REQ-040 SHALL cover: back-to-back MUL 0x10000*0x10000 then SLL 1<<31 with out_ready=1 -> results 0 and 0x80000000 on consecutive cycles.
